// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and sync-window helpers.
// Provides default porch/sync widths, derived totals, the coordinate width
// and functions that turn visible/front/sync widths into sync windows.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COORD_MAX = 1 << COORD_W;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // First coordinate inside the sync pulse.
    function automatic int unsigned sync_start(input int unsigned visible,
                                               input int unsigned front);
        return visible + front;
    endfunction

    // Last coordinate inside the sync pulse (inclusive).
    function automatic int unsigned sync_end(input int unsigned visible,
                                             input int unsigned front,
                                             input int unsigned sync);
        return visible + front + sync - 1;
    endfunction

endpackage

// File: rtl/pixel_enable_divider.sv
// Pixel-enable strobe generator.
// Ports: clk, rst_n (async active-low), pix_en (high for the last system
// clock of every CLK_DIV-cycle pixel period; constantly high when CLK_DIV=1).
module pixel_enable_divider #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int unsigned     CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;

    // Modulo-CLK_DIV counter.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // Decoded from the counter so it is valid (and correct) during reset too.
    assign pix_en = (div_cnt_q == CNT_LAST);

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator (640x480@60 Hz by default).
// Ports: clk, rst_n (async active-low); pix_en strobe; current_pixel_x/y
// raster coordinates; hsync/vsync (polarity set by SYNC_ACTIVE_LOW);
// video_on (visible area); frame_tick (one clk on last pixel of a frame).
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT         = DEF_H_FRONT,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BACK          = DEF_H_BACK,
    parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT         = DEF_V_FRONT,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BACK          = DEF_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_en,
    output logic [COORD_W-1:0] current_pixel_x,
    output logic [COORD_W-1:0] current_pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               frame_tick
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Reject timings the 10-bit counters cannot represent.
    if (H_TOTAL > COORD_MAX) begin : g_bad_h_total
        $error("vga_timing_generator: H_TOTAL exceeds coordinate range");
    end
    if (V_TOTAL > COORD_MAX) begin : g_bad_v_total
        $error("vga_timing_generator: V_TOTAL exceeds coordinate range");
    end
    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_clk_div
        $error("vga_timing_generator: CLK_DIV must be 1..8");
    end

    logic               pix_en_w;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;

    pixel_enable_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_enable_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en_w)
    );

    // Raster counters plus sync/blank decoded from the next coordinates,
    // so the registered flags change on the same edge as x/y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en_w) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        hsync_d    = (x_d >= HS_START && x_d <= HS_END) ? SYNC_ON : SYNC_OFF;
        vsync_d    = (y_d >= VS_START && y_d <= VS_END) ? SYNC_ON : SYNC_OFF;
        video_on_d = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= SYNC_OFF;
            vsync_q    <= SYNC_OFF;
            video_on_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign pix_en          = pix_en_w;
    assign current_pixel_x = x_q;
    assign current_pixel_y = y_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign video_on        = video_on_q;
    // Qualified with pix_en so it lasts one clk although (last x, last y) spans CLK_DIV clks.
    assign frame_tick      = pix_en_w && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator.
// dut_a: default 640x480 timing, CLK_DIV=2, active-low sync.
// dut_b: default timing, CLK_DIV=1, active-high sync.
// dut_c/dut_d: shrunk 32x19 raster (CLK_DIV=2 / CLK_DIV=1 active-high) so
// frame-level behaviour fits in a short run.
module tb_vga_timing_generator;

    logic clk;
    logic rst_a_n, rst_b_n, rst_c_n, rst_d_n;

    logic       a_pix_en, a_hsync, a_vsync, a_video_on, a_frame_tick;
    logic [9:0] a_x, a_y;
    logic       b_pix_en, b_hsync, b_vsync, b_video_on, b_frame_tick;
    logic [9:0] b_x, b_y;
    logic       c_pix_en, c_hsync, c_vsync, c_video_on, c_frame_tick;
    logic [9:0] c_x, c_y;
    logic       d_pix_en, d_hsync, d_vsync, d_video_on, d_frame_tick;
    logic [9:0] d_x, d_y;

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_generator #(.CLK_DIV(2), .SYNC_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .pix_en(a_pix_en),
        .current_pixel_x(a_x), .current_pixel_y(a_y),
        .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on), .frame_tick(a_frame_tick)
    );

    vga_timing_generator #(.CLK_DIV(1), .SYNC_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .pix_en(b_pix_en),
        .current_pixel_x(b_x), .current_pixel_y(b_y),
        .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on), .frame_tick(b_frame_tick)
    );

    // 32x19 raster: hsync x 20..27, vsync y 14..15, visible 16x12.
    vga_timing_generator #(
        .CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(1'b1)
    ) dut_c (
        .clk(clk), .rst_n(rst_c_n), .pix_en(c_pix_en),
        .current_pixel_x(c_x), .current_pixel_y(c_y),
        .hsync(c_hsync), .vsync(c_vsync), .video_on(c_video_on), .frame_tick(c_frame_tick)
    );

    vga_timing_generator #(
        .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(1'b0)
    ) dut_d (
        .clk(clk), .rst_n(rst_d_n), .pix_en(d_pix_en),
        .current_pixel_x(d_x), .current_pixel_y(d_y),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on), .frame_tick(d_frame_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_low, hs_first, hs_last, hs_high, en_cnt;
        int c_first, c_second, c_count, d_first, d_second, d_count;
        int c_tick_x, c_tick_y, c_after_x, c_after_y, d_tick_x, d_tick_y;
        int c_vs_low, c_vs_bad, c_hs_low, c_vid, c_vid_bad, c_en;
        int d_hs_high, d_vs_high, d_vid, d_en;

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0; rst_d_n = 1'b0;
        repeat (3) tick();

        // Reset values while clocks run.
        chk("a_rst_x", a_x, 0);
        chk("a_rst_y", a_y, 0);
        chk("a_rst_video_on", a_video_on, 0);
        chk("a_rst_hsync", a_hsync, 1);
        chk("a_rst_vsync", a_vsync, 1);
        chk("a_rst_pix_en", a_pix_en, 0);
        chk("a_rst_frame_tick", a_frame_tick, 0);
        chk("b_rst_pix_en", b_pix_en, 1);
        chk("b_rst_hsync", b_hsync, 0);
        chk("b_rst_vsync", b_vsync, 0);
        chk("b_rst_y", b_y, 0);
        chk("b_rst_video_on", b_video_on, 0);
        chk("b_rst_frame_tick", b_frame_tick, 0);

        // Release between edges.
        #4; rst_a_n = 1'b1; rst_b_n = 1'b1; #1;
        chk("a_rel_pix_en0", a_pix_en, 0);
        tick();
        chk("a_e1_pix_en", a_pix_en, 1);
        chk("a_e1_x", a_x, 0);
        chk("a_e1_video_on", a_video_on, 1);
        chk("b_e1_x", b_x, 1);
        tick();
        chk("a_e2_pix_en", a_pix_en, 0);
        chk("a_e2_x", a_x, 1);
        chk("b_e2_x", b_x, 2);
        tick();
        chk("a_e3_pix_en", a_pix_en, 1);
        chk("a_e3_x", a_x, 1);
        tick();
        chk("a_e4_x", a_x, 2);
        chk("a_e4_pix_en", a_pix_en, 0);

        // Line wrap on dut_a.
        for (int i = 0; i < 4000; i++) begin
            if (a_x == 10'd799 && a_pix_en) break;
            tick();
        end
        chk("a_last_x", a_x, 799);
        chk("a_last_y", a_y, 0);
        tick();
        chk("a_wrap_x", a_x, 0);
        chk("a_wrap_y", a_y, 1);

        // One full line of dut_a: hsync low window.
        hs_low = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 1600; i++) begin
            if (a_hsync == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(a_x);
                hs_last = int'(a_x);
            end
            tick();
        end
        chk("a_hsync_low_clks", hs_low, 192);
        chk("a_hsync_first_x", hs_first, 656);
        chk("a_hsync_last_x", hs_last, 751);
        chk("a_line2_y", a_y, 2);

        // video_on falls with x 639->640 and rises at the wrap.
        for (int i = 0; i < 1600; i++) begin
            if (a_x == 10'd639) break;
            tick();
        end
        chk("a_vid_at_639", a_video_on, 1);
        for (int i = 0; i < 4; i++) begin
            if (a_x == 10'd640) break;
            tick();
        end
        chk("a_x_640", a_x, 640);
        chk("a_vid_at_640", a_video_on, 0);
        chk("a_vsync_y2", a_vsync, 1);
        for (int i = 0; i < 400; i++) begin
            if (a_x == 10'd0) break;
            tick();
        end
        chk("a_wrap3_y", a_y, 3);
        chk("a_vid_at_wrap", a_video_on, 1);

        // Asynchronous mid-frame reset.
        for (int i = 0; i < 1600; i++) begin
            if (a_x == 10'd300) break;
            tick();
        end
        chk("a_pre_rst_x", a_x, 300);
        #4; rst_a_n = 1'b0; #1;
        chk("a_async_rst_x", a_x, 0);
        chk("a_async_rst_y", a_y, 0);
        chk("a_async_rst_video_on", a_video_on, 0);
        chk("a_async_rst_hsync", a_hsync, 1);
        chk("a_async_rst_pix_en", a_pix_en, 0);
        tick();
        #4; rst_a_n = 1'b1;
        tick();
        chk("a_rerun_x0", a_x, 0);
        chk("a_rerun_video_on", a_video_on, 1);
        tick();
        chk("a_rerun_x1", a_x, 1);

        // dut_b: active-high hsync window and free-running pix_en.
        for (int i = 0; i < 1000; i++) begin
            if (b_hsync == 1'b1) break;
            tick();
        end
        chk("b_hsync_first_x", b_x, 656);
        hs_high = 0; en_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (b_hsync) hs_high++;
            if (b_pix_en) en_cnt++;
            tick();
        end
        chk("b_hsync_high_clks", hs_high, 96);
        chk("b_pix_en_clks", en_cnt, 800);

        // Frame-level checks on the shrunk rasters (frames of 1216 and 608 clks).
        #4; rst_c_n = 1'b1; rst_d_n = 1'b1;
        c_first = -1; c_second = -1; c_count = 0;
        d_first = -1; d_second = -1; d_count = 0;
        c_tick_x = -1; c_tick_y = -1; c_after_x = -1; c_after_y = -1;
        d_tick_x = -1; d_tick_y = -1;
        c_vs_low = 0; c_vs_bad = 0; c_hs_low = 0; c_vid = 0; c_vid_bad = 0; c_en = 0;
        d_hs_high = 0; d_vs_high = 0; d_vid = 0; d_en = 0;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (c_first >= 0 && k == c_first + 1) begin
                c_after_x = int'(c_x);
                c_after_y = int'(c_y);
            end
            if (c_frame_tick) begin
                c_count++;
                if (c_first < 0) begin
                    c_first = k;
                    c_tick_x = int'(c_x);
                    c_tick_y = int'(c_y);
                end else if (c_second < 0) begin
                    c_second = k;
                end
            end
            if (d_frame_tick) begin
                d_count++;
                if (d_first < 0) begin
                    d_first = k;
                    d_tick_x = int'(d_x);
                    d_tick_y = int'(d_y);
                end else if (d_second < 0) begin
                    d_second = k;
                end
            end
            // One complete dut_c frame: edges 1216..2431.
            if (k >= 1216 && k <= 2431) begin
                if (!c_vsync) begin
                    c_vs_low++;
                    if (c_y < 10'd14 || c_y > 10'd15) c_vs_bad++;
                end
                if (!c_hsync) c_hs_low++;
                if (c_video_on) begin
                    c_vid++;
                    if (c_y >= 10'd12 || c_x >= 10'd16) c_vid_bad++;
                end
                if (c_pix_en) c_en++;
            end
            // One complete dut_d frame: edges 608..1215.
            if (k >= 608 && k <= 1215) begin
                if (d_hsync) d_hs_high++;
                if (d_vsync) d_vs_high++;
                if (d_video_on) d_vid++;
                if (d_pix_en) d_en++;
            end
        end
        chk("c_first_tick_edge", c_first, 1215);
        chk("c_tick_period", c_second - c_first, 1216);
        chk("c_tick_count", c_count, 2);
        chk("c_tick_x", c_tick_x, 31);
        chk("c_tick_y", c_tick_y, 18);
        chk("c_after_tick_x", c_after_x, 0);
        chk("c_after_tick_y", c_after_y, 0);
        chk("c_vsync_low_clks", c_vs_low, 128);
        chk("c_vsync_outside", c_vs_bad, 0);
        chk("c_hsync_low_clks", c_hs_low, 304);
        chk("c_video_on_clks", c_vid, 384);
        chk("c_video_on_blank", c_vid_bad, 0);
        chk("c_pix_en_clks", c_en, 608);
        chk("d_first_tick_edge", d_first, 607);
        chk("d_tick_period", d_second - d_first, 608);
        chk("d_tick_count", d_count, 4);
        chk("d_tick_x", d_tick_x, 31);
        chk("d_tick_y", d_tick_y, 18);
        chk("d_hsync_high_clks", d_hs_high, 152);
        chk("d_vsync_high_clks", d_vs_high, 64);
        chk("d_video_on_clks", d_vid, 192);
        chk("d_pix_en_clks", d_en, 608);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock. Produces the pixel-enable strobe, the current pixel coordinates, hsync/vsync and the active-video flag. It is the upstream source of `current_pixel_x`/`current_pixel_y` for the effective-clock and frame-tick logic and for all pixel renderers. It also emits a one-cycle end-of-frame strobe for game-state updates.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; legal range 1..8.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal timing in pixels. H_TOTAL = 800.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical timing in lines. V_TOTAL = 525.
- `SYNC_ACTIVE_LOW`, 1: when 1, hsync and vsync are low while asserted.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pix_en` output 1: one-`clk` strobe; the coordinates advance on the edge that ends this cycle.
- `current_pixel_x` output 10: horizontal counter, range 0..H_TOTAL-1.
- `current_pixel_y` output 10: vertical counter, range 0..V_TOTAL-1.
- `hsync` output 1: horizontal sync, polarity per `SYNC_ACTIVE_LOW`.
- `vsync` output 1: vertical sync, polarity per `SYNC_ACTIVE_LOW`.
- `video_on` output 1: high when x < H_VISIBLE and y < V_VISIBLE.
- `frame_tick` output 1: one-`clk` pulse on the last pixel period of each frame.

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps to 0.
  - `pix_en` = (`div_cnt` == CLK_DIV-1).
  - With CLK_DIV=1, `pix_en` is constantly 1 after reset.
- X counter: increments on each `clk` edge where `pix_en`=1. At H_TOTAL-1 it wraps to 0.
- Y counter: increments when x wraps. At V_TOTAL-1 it wraps to 0, together with x.
- Each (x,y) value is held for exactly CLK_DIV `clk` cycles.
- Sync windows:
  - hsync asserted for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vsync asserted for y in [490, 491].
- Registered outputs: `hsync`, `vsync` and `video_on` are decoded from the next-state counter values. They therefore change on the same edge as x/y, with zero skew relative to the coordinates.
- `frame_tick` = `pix_en` AND x==H_TOTAL-1 AND y==V_TOTAL-1. It is a combinational decode of registered state, high for exactly one `clk` per frame.
- Arithmetic: unsigned 10-bit throughout. Elaboration fails if H_TOTAL > 1024 or V_TOTAL > 1024.
- Reset (asserted, at any time, including mid-frame):
  - `div_cnt`=0, x=0, y=0.
  - `video_on`=0.
  - hsync and vsync at their inactive level (1 when `SYNC_ACTIVE_LOW`).
  - `pix_en` and `frame_tick` are decoded from the reset state, so they are 1 during reset only when CLK_DIV=1; otherwise 0.

## Timing
- First rising edge after `rst_n` deasserts: `video_on` becomes 1; x/y stay (0,0) unless CLK_DIV=1.
- First coordinate advance: on edge number CLK_DIV after reset release.
- Line period = 800·CLK_DIV `clk` cycles. Frame period = 420000·CLK_DIV cycles (16.8 ms at CLK_DIV=2).
- `video_on` falls on the edge where x goes 639→640. It rises where x wraps to 0 with y < 480.
- After reset release, `frame_tick` first occurs 420000·CLK_DIV−1 edges later, i.e. in the cycle before that count of cycles completes.
- The (x==639, y==479) condition is true for CLK_DIV consecutive `clk` cycles. Downstream logic that needs a single-cycle event must qualify it with `pix_en`.

## Structure
- Shared package / include `vga_timing_pkg`: 640x480 default constants, H_TOTAL/V_TOTAL, sync start/end derivations and the coordinate width (10).
- One sub-module, `pixel_enable_divider`: parameter CLK_DIV, ports `clk`, `rst_n`, output `pix_en`.
- The counters and sync/blank registers live in the top module.

## Test plan
- Reset with CLK_DIV=2: all outputs hold their reset values (x=0, y=0, `video_on`=0, hsync=vsync=1, `pix_en`=0). After release, `pix_en` toggles 0,1,0,1 and x reaches 1 on the 2nd edge.
- Line wrap: run to x=799, y=0 → next advance gives x=0, y=1. hsync is low exactly for x 656..751, i.e. 96 pixels (192 clks).
- Frame wrap: at (799,524), `frame_tick`=1 for exactly one clk → next coordinate (0,0). Consecutive `frame_tick` pulses are 840000 clks apart.
- Blanking: `video_on` falls in the same cycle x becomes 640. It stays low for all of y 480..524. vsync is low only for y 490..491.
- Mid-frame reset: assert `rst_n`=0 at (300,200) asynchronously, between edges → outputs reach reset values immediately, without waiting for a clock edge. After release the sequence restarts from (0,0).
- CLK_DIV=1, `SYNC_ACTIVE_LOW`=0: `pix_en` constantly 1 and x increments every clk. hsync is high for x 656..751. Frame period is 420000 clks.
